moquanmips_bus_arbiter: RTL and testbench
=========================================

// Module: moquanmips_bus_arbiter
// PURPOSE
//  Shares the single SOPC memory port between the CPU data (load/store) master M0
//  and the instruction-fetch master M1. Uses fixed-priority or round-robin arbitration.
//  Sequences one slave transaction at a time with a req/ack handshake and a no-ack
//  timeout. Drives a stall request to the pipeline control unit while any master waits.
// PARAMETERS
//  AW        32  address width
//  DW        32  data width (byte selects = DW/8)
//  PRIO_MODE 0   0 = fixed, M0 (data) wins ties; 1 = round-robin
//  TIMEOUT   16  cycles in BUSY without s_ack_i before abort; 0 disables timeout
// PORTS
//  clk         in   1     system clock, all state on rising edge
//  rst         in   1     asynchronous, active-low reset (0 = reset)
//  m0_req_i    in   1     M0 (data) request; held high until m0_ack_o seen
//  m0_we_i     in   1     M0 write enable
//  m0_addr_i   in   AW    M0 address
//  m0_wdata_i  in   DW    M0 write data
//  m0_sel_i    in   DW/8  M0 byte selects
//  m0_rdata_o  out  DW    M0 read data, valid with m0_ack_o
//  m0_ack_o    out  1     M0 completion pulse (1 cycle)
//  m0_err_o    out  1     M0 timeout flag, valid with m0_ack_o
//  m1_*        -    -     same set as m0_* for the instruction-fetch master
//  s_stb_o     out  1     slave strobe, high for whole transaction
//  s_we_o      out  1     slave write enable (latched)
//  s_addr_o    out  AW    slave address (latched)
//  s_wdata_o   out  DW    slave write data (latched)
//  s_sel_o     out  DW/8  slave byte selects (latched)
//  s_rdata_i   in   DW    slave read data, sampled when s_ack_i=1
//  s_ack_i     in   1     slave completion, 1 cycle
//  stallreq_o  out  1     comb: (m0_req_i & ~m0_ack_o) | (m1_req_i & ~m1_ack_o)
//  gnt_o       out  2     one-hot current owner {M1,M0}; 0 when idle
// BEHAVIOUR
//  FSM: IDLE -> BUSY -> DONE -> IDLE.
//  Reset: state=IDLE; s_*, m*_ack_o, m*_err_o, m*_rdata_o, gnt_o all 0; timer=0;
//   last_gnt=M1, so M0 wins the first round-robin tie. Reset acts immediately, mid-transaction included.
//  IDLE: if any req, pick winner; latch its we/addr/wdata/sel into s_*; set gnt_o.
//   Go to BUSY; s_stb_o=1 in the first BUSY cycle. Req-to-strobe latency = 1 cycle.
//  Arbitration: one requester wins. Both requesting: PRIO_MODE=0 gives M0;
//   PRIO_MODE=1 gives the master other than last_gnt. last_gnt updates on every grant.
//  BUSY: s_* stay stable; timer increments each cycle.
//   s_ack_i=1: winner rdata_o <= s_rdata_i (0 on writes), ack_o <= 1, err_o <= 0; go to DONE.
//   Else if TIMEOUT!=0 and timer==TIMEOUT-1: ack_o <= 1, err_o <= 1, rdata_o <= 0; go to DONE.
//   The timeout abort therefore comes exactly TIMEOUT strobe cycles after s_stb_o rose.
//  DONE: s_stb_o=0; ack_o/err_o high for this cycle only; requests ignored.
//   Master drops or renews req for the next IDLE. Then IDLE; gnt_o=0; timer=0.
//  Throughput: 3 cycles per transaction minimum (slave acks in the first strobe cycle).
//  The non-granted master's ack/err stay 0; its request stays pending, stallreq_o held.
//  A winner that drops req during BUSY is not supported; the transaction still completes and acks.
//  s_ack_i outside BUSY is ignored. m*_rdata_o holds its value until the next ack to that master.
// TESTING
//  1 M0 read 0x0000_0100; slave acks 2nd strobe cycle with 0xDEADBEEF -> s_stb_o 2 cycles,
//    m0_ack_o 1-cycle pulse, m0_rdata_o=0xDEADBEEF, m0_err_o=0, gnt_o=01 then 00.
//  2 PRIO_MODE=0, M0 and M1 raised in the same cycle -> M0 served first, M1 next;
//    stallreq_o stays high until m1_ack_o.
//  3 PRIO_MODE=1, both hold req for 4 transactions -> grant order M0,M1,M0,M1;
//    every DONE followed by IDLE.
//  4 TIMEOUT=8, slave never acks M1 fetch -> m1_ack_o=1, m1_err_o=1, m1_rdata_o=0
//    exactly 8 cycles after s_stb_o rises; s_stb_o low next cycle.
//  5 M0 write, sel=4'b0011, wdata=0x0000_1234, addr=0x20 -> slave sees exactly these values
//    with s_we_o=1; m0_rdata_o=0.
//  6 rst driven low mid-BUSY between clock edges -> s_stb_o, gnt_o and acks drop at once
//    (asynchronously); after release, a fresh tie goes to M0.

Source files
------------

// File: rtl/moquanmips_bus_arbiter_if.sv
// Bus bundle around the shared SOPC memory port: two requesting masters
// (M0 = load/store, M1 = instruction fetch), the single slave port, and the
// stall/grant status seen by the pipeline control unit.
interface moquanmips_bus_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   // M0: CPU data master
   logic              m0_req_i;
   logic              m0_we_i;
   logic [AW-1:0]     m0_addr_i;
   logic [DW-1:0]     m0_wdata_i;
   logic [DW/8-1:0]   m0_sel_i;
   logic [DW-1:0]     m0_rdata_o;
   logic              m0_ack_o;
   logic              m0_err_o;
   // M1: instruction-fetch master
   logic              m1_req_i;
   logic              m1_we_i;
   logic [AW-1:0]     m1_addr_i;
   logic [DW-1:0]     m1_wdata_i;
   logic [DW/8-1:0]   m1_sel_i;
   logic [DW-1:0]     m1_rdata_o;
   logic              m1_ack_o;
   logic              m1_err_o;
   // shared slave port
   logic              s_stb_o;
   logic              s_we_o;
   logic [AW-1:0]     s_addr_o;
   logic [DW-1:0]     s_wdata_o;
   logic [DW/8-1:0]   s_sel_o;
   logic [DW-1:0]     s_rdata_i;
   logic              s_ack_i;
   // pipeline status
   logic              stallreq_o;
   logic [1:0]        gnt_o;

   // arbiter's view: it is the slave of both masters and drives the memory port
   modport slave (
      input  m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i, m0_sel_i,
      output m0_rdata_o, m0_ack_o, m0_err_o,
      input  m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_sel_i,
      output m1_rdata_o, m1_ack_o, m1_err_o,
      output s_stb_o, s_we_o, s_addr_o, s_wdata_o, s_sel_o,
      input  s_rdata_i, s_ack_i,
      output stallreq_o, gnt_o
   );

   // environment's view: masters, memory and pipeline control
   modport master (
      output m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i, m0_sel_i,
      input  m0_rdata_o, m0_ack_o, m0_err_o,
      output m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_sel_i,
      input  m1_rdata_o, m1_ack_o, m1_err_o,
      input  s_stb_o, s_we_o, s_addr_o, s_wdata_o, s_sel_o,
      output s_rdata_i, s_ack_i,
      input  stallreq_o, gnt_o
   );
endinterface

// File: rtl/moquanmips_bus_arbiter.sv
// Two-master arbiter for the single SOPC memory port. One transaction at a
// time: IDLE picks a winner and latches its request, BUSY strobes the slave
// until ack or timeout, DONE pulses the winner's ack for one cycle.
module moquanmips_bus_arbiter #(
   parameter int AW        = 32,
   parameter int DW        = 32,
   parameter int PRIO_MODE = 0,   // 0 = fixed (M0 wins ties), 1 = round-robin
   parameter int TIMEOUT   = 16   // BUSY cycles without ack before abort; 0 = never
) (
   input  logic                     clk,
   input  logic                     rst,   // asynchronous, active low
   moquanmips_bus_arbiter_if.slave  bus
);
   localparam int SW = DW / 8;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e                 state_q,   state_d;
   logic [1:0]             gnt_q,     gnt_d;     // one-hot owner {M1,M0}
   logic                   last_q,    last_d;    // index of the last granted master
   logic [TW-1:0]          timer_q,   timer_d;
   logic                   s_we_q,    s_we_d;
   logic [AW-1:0]          s_addr_q,  s_addr_d;
   logic [DW-1:0]          s_wdata_q, s_wdata_d;
   logic [SW-1:0]          s_sel_q,   s_sel_d;
   logic [1:0][DW-1:0]     rdata_q,   rdata_d;   // per-master read data, index = master
   logic [1:0]             ack_q,     ack_d;
   logic [1:0]             err_q,     err_d;

   logic [1:0]             req;
   logic                   win;                  // arbitration winner index
   logic                   owner;                // master that owns the current transaction

   assign req   = {bus.m1_req_i, bus.m0_req_i};
   assign owner = gnt_q[1];

   // Next-state, arbitration and per-transaction bookkeeping
   always_comb begin
      // NOTE: every variable gets a default before the case, so no path leaves one unassigned and no latch is inferred.
      state_d   = state_q;
      gnt_d     = gnt_q;
      last_d    = last_q;
      timer_d   = timer_q;
      s_we_d    = s_we_q;
      s_addr_d  = s_addr_q;
      s_wdata_d = s_wdata_q;
      s_sel_d   = s_sel_q;
      rdata_d   = rdata_q;
      ack_d     = 2'b00;       // acks and errors are single-cycle pulses
      err_d     = 2'b00;

      // a tie goes to M0 (fixed) or to whoever was not served last (round-robin)
      if (req == 2'b11) begin
         win = (PRIO_MODE == 0) ? 1'b0 : ~last_q;
      end else begin
         win = req[1];
      end

      case (state_q)
         ST_IDLE: begin
            if (|req) begin
               state_d   = ST_BUSY;
               gnt_d     = win ? 2'b10 : 2'b01;
               last_d    = win;
               timer_d   = '0;
               s_we_d    = win ? bus.m1_we_i    : bus.m0_we_i;
               s_addr_d  = win ? bus.m1_addr_i  : bus.m0_addr_i;
               s_wdata_d = win ? bus.m1_wdata_i : bus.m0_wdata_i;
               s_sel_d   = win ? bus.m1_sel_i   : bus.m0_sel_i;
            end
         end
         ST_BUSY: begin
            timer_d = timer_q + TW'(1);
            if (bus.s_ack_i) begin
               state_d        = ST_DONE;
               ack_d[owner]   = 1'b1;
               rdata_d[owner] = s_we_q ? '0 : bus.s_rdata_i;
            end else if ((TIMEOUT != 0) && (timer_q == TIMER_LAST)) begin
               state_d        = ST_DONE;
               ack_d[owner]   = 1'b1;
               err_d[owner]   = 1'b1;
               rdata_d[owner] = '0;
            end
         end
         ST_DONE: begin
            // requests are not looked at here; the next IDLE cycle arbitrates
            state_d = ST_IDLE;
            gnt_d   = 2'b00;
            timer_d = '0;
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = 2'b00;
            timer_d = '0;
         end
      endcase
   end

   // State and output registers; reset clears everything at once, mid-transaction included
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         gnt_q     <= 2'b00;
         last_q    <= 1'b1;      // M1 counts as last served so M0 wins the first tie
         timer_q   <= '0;
         s_we_q    <= 1'b0;
         s_addr_q  <= '0;
         s_wdata_q <= '0;
         s_sel_q   <= '0;
         rdata_q   <= '0;
         ack_q     <= 2'b00;
         err_q     <= 2'b00;
      end else begin
         // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         last_q    <= last_d;
         timer_q   <= timer_d;
         s_we_q    <= s_we_d;
         s_addr_q  <= s_addr_d;
         s_wdata_q <= s_wdata_d;
         s_sel_q   <= s_sel_d;
         rdata_q   <= rdata_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
      end
   end

   assign bus.s_stb_o    = (state_q == ST_BUSY);
   assign bus.s_we_o     = s_we_q;
   assign bus.s_addr_o   = s_addr_q;
   assign bus.s_wdata_o  = s_wdata_q;
   assign bus.s_sel_o    = s_sel_q;

   assign bus.m0_rdata_o = rdata_q[0];
   assign bus.m0_ack_o   = ack_q[0];
   assign bus.m0_err_o   = err_q[0];
   assign bus.m1_rdata_o = rdata_q[1];
   assign bus.m1_ack_o   = ack_q[1];
   assign bus.m1_err_o   = err_q[1];

   assign bus.gnt_o      = gnt_q;
   assign bus.stallreq_o = (bus.m0_req_i & ~ack_q[0]) | (bus.m1_req_i & ~ack_q[1]);

endmodule

// File: tb/tb_moquanmips_bus_arbiter.sv
// Bench for moquanmips_bus_arbiter. Two instances share one set of stimulus:
// dut0 is fixed-priority with an 8-cycle timeout, dut1 is round-robin with the
// default 16-cycle timeout; sel_dut chooses which one is being observed.
// Expected values come from a transaction-level model of the arbitration rules.
module tb_moquanmips_bus_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;
   localparam int TMO0 = 8;
   localparam int TMO1 = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst;
   logic [1:0]       m_req, m_we;
   logic [AW-1:0]    m_addr  [2];
   logic [DW-1:0]    m_wdata [2];
   logic [SW-1:0]    m_sel   [2];
   logic [DW-1:0]    s_rdata;
   logic             s_ack;
   logic             sel_dut;

   moquanmips_bus_arbiter_if #(.AW(AW), .DW(DW)) bus0 ();
   moquanmips_bus_arbiter_if #(.AW(AW), .DW(DW)) bus1 ();

   moquanmips_bus_arbiter #(.AW(AW), .DW(DW), .PRIO_MODE(0), .TIMEOUT(TMO0)) dut0 (
      .clk(clk), .rst(rst), .bus(bus0));
   moquanmips_bus_arbiter #(.AW(AW), .DW(DW), .PRIO_MODE(1), .TIMEOUT(TMO1)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1));

   assign bus0.m0_req_i   = m_req[0];
   assign bus0.m0_we_i    = m_we[0];
   assign bus0.m0_addr_i  = m_addr[0];
   assign bus0.m0_wdata_i = m_wdata[0];
   assign bus0.m0_sel_i   = m_sel[0];
   assign bus0.m1_req_i   = m_req[1];
   assign bus0.m1_we_i    = m_we[1];
   assign bus0.m1_addr_i  = m_addr[1];
   assign bus0.m1_wdata_i = m_wdata[1];
   assign bus0.m1_sel_i   = m_sel[1];
   assign bus0.s_rdata_i  = s_rdata;
   assign bus0.s_ack_i    = s_ack;
   assign bus1.m0_req_i   = m_req[0];
   assign bus1.m0_we_i    = m_we[0];
   assign bus1.m0_addr_i  = m_addr[0];
   assign bus1.m0_wdata_i = m_wdata[0];
   assign bus1.m0_sel_i   = m_sel[0];
   assign bus1.m1_req_i   = m_req[1];
   assign bus1.m1_we_i    = m_we[1];
   assign bus1.m1_addr_i  = m_addr[1];
   assign bus1.m1_wdata_i = m_wdata[1];
   assign bus1.m1_sel_i   = m_sel[1];
   assign bus1.s_rdata_i  = s_rdata;
   assign bus1.s_ack_i    = s_ack;

   // observed outputs of the selected instance
   logic             o_stb, o_we, o_stall;
   logic [AW-1:0]    o_addr;
   logic [DW-1:0]    o_wdata;
   logic [SW-1:0]    o_sel;
   logic [1:0]       o_gnt, o_ack, o_err;
   logic [DW-1:0]    o_rdata [2];

   always_comb begin
      if (sel_dut == 1'b0) begin
         o_stb = bus0.s_stb_o; o_we = bus0.s_we_o; o_addr = bus0.s_addr_o;
         o_wdata = bus0.s_wdata_o; o_sel = bus0.s_sel_o; o_stall = bus0.stallreq_o;
         o_gnt = bus0.gnt_o;
         o_ack = {bus0.m1_ack_o, bus0.m0_ack_o};
         o_err = {bus0.m1_err_o, bus0.m0_err_o};
         o_rdata[0] = bus0.m0_rdata_o; o_rdata[1] = bus0.m1_rdata_o;
      end else begin
         o_stb = bus1.s_stb_o; o_we = bus1.s_we_o; o_addr = bus1.s_addr_o;
         o_wdata = bus1.s_wdata_o; o_sel = bus1.s_sel_o; o_stall = bus1.stallreq_o;
         o_gnt = bus1.gnt_o;
         o_ack = {bus1.m1_ack_o, bus1.m0_ack_o};
         o_err = {bus1.m1_err_o, bus1.m0_err_o};
         o_rdata[0] = bus1.m0_rdata_o; o_rdata[1] = bus1.m1_rdata_o;
      end
   end

   // scoreboard counters and model state
   int            n_cmp  = 0;
   int            n_fail = 0;
   int            prio;            // 0 fixed, 1 round-robin
   int            tmo;             // timeout of the observed instance
   int            last_w;          // master served most recently
   logic [DW-1:0] exp_rdata [2];   // read data each master should be holding

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic new_req(input int m);
      m_req[m]   = 1'b1;
      m_we[m]    = 1'($urandom_range(0, 1));
      m_addr[m]  = $urandom & ~32'h3;
      m_wdata[m] = $urandom;
      m_sel[m]   = 4'($urandom);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_stb"},   o_stb,   1'b0);
      check({tag, "_gnt"},   o_gnt,   2'b00);
      check({tag, "_ack"},   o_ack,   2'b00);
      check({tag, "_rd0"},   o_rdata[0], exp_rdata[0]);
      check({tag, "_rd1"},   o_rdata[1], exp_rdata[1]);
   endtask

   task automatic do_reset();
      rst   = 1'b0;
      m_req = 2'b00;
      m_we  = 2'b00;
      s_ack = 1'b0;
      s_rdata = '0;
      for (int m = 0; m < 2; m++) begin
         m_addr[m] = '0; m_wdata[m] = '0; m_sel[m] = '0;
      end
      last_w = 1;
      exp_rdata[0] = '0;
      exp_rdata[1] = '0;
      tick();
      check_idle("rst");
      check("rst_we",    o_we,    1'b0);
      check("rst_addr",  o_addr,  '0);
      check("rst_wdata", o_wdata, '0);
      check("rst_sel",   o_sel,   '0);
      check("rst_err",   o_err,   2'b00);
      check("rst_stall", o_stall, 1'b0);
      tick();
      rst = 1'b1;
      tick();
   endtask

   // One whole transaction. Entry: #1 after an edge, in an IDLE cycle, with at
   // least one request driven. The slave acks in strobe cycle d (d beyond the
   // timeout means it never does). renew: winner re-requests in its DONE cycle.
   task automatic round(input int d, input logic [DW-1:0] rd, input bit renew);
      int            w;
      bit            abort;
      logic [DW-1:0] rd_exp;
      if (m_req == 2'b11) w = (prio == 0) ? 0 : 1 - last_w;
      else                w = m_req[1] ? 1 : 0;
      last_w = w;
      abort  = (d > tmo);
      rd_exp = (abort || m_we[w]) ? '0 : rd;

      s_ack   = 1'($urandom_range(0, 1));   // must be ignored outside BUSY
      s_rdata = $urandom;
      tick();
      check("gnt",   o_gnt,   (w == 1) ? 2'b10 : 2'b01);
      check("s_we",  o_we,    m_we[w]);
      check("s_addr",  o_addr,  m_addr[w]);
      check("s_wdata", o_wdata, m_wdata[w]);
      check("s_sel",   o_sel,   m_sel[w]);
      check("stall_busy", o_stall, 1'b1);
      for (int k = 1; k <= tmo; k++) begin
         check("stb_busy", o_stb, 1'b1);
         check("ack_busy", o_ack, 2'b00);
         s_ack   = (k == d);
         s_rdata = (k == d) ? rd : DW'($urandom);
         tick();
         if (k == d) break;
      end
      // DONE cycle
      check("stb_done",  o_stb, 1'b0);
      check("gnt_done",  o_gnt, (w == 1) ? 2'b10 : 2'b01);
      check("ack_win",   o_ack[w], 1'b1);
      check("ack_lose",  o_ack[1-w], 1'b0);
      check("err_win",   o_err[w], abort);
      check("err_lose",  o_err[1-w], 1'b0);
      check("rdata_win", o_rdata[w], rd_exp);
      check("rdata_hold_lose", o_rdata[1-w], exp_rdata[1-w]);
      check("stall_done", o_stall, m_req[1-w]);
      exp_rdata[w] = rd_exp;
      s_ack   = 1'($urandom_range(0, 1));
      s_rdata = $urandom;
      if (renew) new_req(w);
      else       m_req[w] = 1'b0;
      tick();
      // back to IDLE
      check_idle("idle_after");
      s_ack = 1'b0;
   endtask

   initial begin
      int d;
      sel_dut = 1'b0;
      prio    = 0;
      tmo     = TMO0;
      do_reset();

      // M0 read, slave acks in the 2nd strobe cycle
      m_req[0] = 1'b1; m_we[0] = 1'b0; m_addr[0] = 32'h0000_0100;
      m_wdata[0] = '0; m_sel[0] = 4'hF;
      round(2, 32'hDEAD_BEEF, 1'b0);

      // simultaneous requests under fixed priority: M0 first, then M1
      new_req(0);
      new_req(1);
      round(1, $urandom, 1'b0);
      check("m1_still_stalled", o_stall, 1'b1);
      round(1, $urandom, 1'b0);
      check("stall_cleared", o_stall, 1'b0);

      // M1 fetch that the slave never acks: aborted after TMO0 strobe cycles
      m_req[1] = 1'b1; m_we[1] = 1'b0; m_addr[1] = 32'h0000_4000;
      m_wdata[1] = '0; m_sel[1] = 4'hF;
      round(1000, 32'hFFFF_FFFF, 1'b0);

      // M0 write with partial byte selects
      m_req[0] = 1'b1; m_we[0] = 1'b1; m_addr[0] = 32'h0000_0020;
      m_wdata[0] = 32'h0000_1234; m_sel[0] = 4'b0011;
      round(1, 32'hCAFE_F00D, 1'b0);

      // random traffic, fixed priority
      for (int i = 0; i < 40; i++) begin
         if (!m_req[0] && ($urandom_range(0, 1) == 1)) new_req(0);
         if (!m_req[1] && ($urandom_range(0, 1) == 1)) new_req(1);
         if (m_req == 2'b00) new_req(int'($urandom_range(0, 1)));
         d = ($urandom_range(0, 3) == 0) ? tmo + int'($urandom_range(0, 2))
                                         : int'($urandom_range(1, 3));
         round(d, $urandom, 1'($urandom_range(0, 1)));
      end

      // switch to the round-robin instance
      sel_dut = 1'b1;
      prio    = 1;
      tmo     = TMO1;
      do_reset();

      // both masters keep requesting for four transactions: M0,M1,M0,M1
      new_req(0);
      new_req(1);
      for (int i = 0; i < 4; i++) round(1, $urandom, 1'b1);
      m_req = 2'b00;
      tick();

      // random traffic, round-robin
      for (int i = 0; i < 40; i++) begin
         if (!m_req[0] && ($urandom_range(0, 1) == 1)) new_req(0);
         if (!m_req[1] && ($urandom_range(0, 1) == 1)) new_req(1);
         if (m_req == 2'b00) new_req(int'($urandom_range(0, 1)));
         d = ($urandom_range(0, 3) == 0) ? tmo + int'($urandom_range(0, 2))
                                         : int'($urandom_range(1, 3));
         round(d, $urandom, 1'($urandom_range(0, 1)));
      end
      m_req = 2'b00;
      tick();

      // asynchronous reset in the middle of a transaction
      new_req(0);
      tick();
      check("pre_rst_stb", o_stb, 1'b1);
      #2 rst = 1'b0;
      #1;
      check("async_rst_stb",   o_stb, 1'b0);
      check("async_rst_gnt",   o_gnt, 2'b00);
      check("async_rst_ack",   o_ack, 2'b00);
      check("async_rst_stall", o_stall, 1'b1);
      tick();
      rst = 1'b1;
      last_w = 1;
      exp_rdata[0] = '0;
      exp_rdata[1] = '0;
      new_req(0);
      new_req(1);
      round(1, $urandom, 1'b0);
      round(2, $urandom, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
